// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> pipeline_ctrl handshake bundle: decode metadata and hit strobes in,
// stage enables, flushes, forwarding selects and halt out.
interface pipeline_ctrl_if #(
    parameter int STAGES = 4,
    parameter int REG_W  = 5,
    parameter int FW     = $clog2(STAGES)
);
    logic              ihit;
    logic              dhit;
    logic [REG_W-1:0]  dec_rsel1;
    logic [REG_W-1:0]  dec_rsel2;
    logic              dec_wen;
    logic [REG_W-1:0]  dec_wsel;
    logic              dec_load;
    logic              dec_uses_rt;
    logic              dec_halt;
    logic              br_taken;
    logic              mem_req;
    logic              pc_en;
    logic [STAGES-1:0] pipe_en;
    logic [STAGES-1:0] flush;
    logic [FW-1:0]     fwd_a;
    logic [FW-1:0]     fwd_b;
    logic              halt;
    logic              stall_load;

    modport master (
        output ihit, dhit, dec_rsel1, dec_rsel2, dec_wen, dec_wsel, dec_load,
               dec_uses_rt, dec_halt, br_taken, mem_req,
        input  pc_en, pipe_en, flush, fwd_a, fwd_b, halt, stall_load
    );

    modport slave (
        input  ihit, dhit, dec_rsel1, dec_rsel2, dec_wen, dec_wsel, dec_load,
               dec_uses_rt, dec_halt, br_taken, mem_req,
        output pc_en, pipe_en, flush, fwd_a, fwd_b, halt, stall_load
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Depth-parametrised MIPS pipeline sequencer: stall/flush/enable generation, EX forwarding, sticky halt.
// Optional PIPE_PERF_CNT_EN adds cyc_cnt/stall_cnt/flush_cnt performance counters.
module pipeline_ctrl #(
    parameter int STAGES = 4,
    parameter int REG_W  = 5,
    parameter int FW     = $clog2(STAGES)
) (
    input  logic              CLK,
    input  logic              nRST,
    pipeline_ctrl_if.slave    bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);
    typedef struct packed {
        logic             valid;
        logic             wen;
        logic [REG_W-1:0] wsel;
        logic             load;
        logic             halt;
    } rec_t;

    rec_t [STAGES-1:1] rec_q, rec_d;
    logic [REG_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
    logic              urt_q, urt_d;
    logic              halt_q, halt_d;

    logic              advance, hz, shift_en;
    logic              pc_en;
    logic [STAGES-1:0] pipe_en, flush;
    logic              stall_load;
    logic [FW-1:0]     fwd_a, fwd_b;

    // The last record's load/halt flags have no consumer beyond it.
    logic unused_rec;
    assign unused_rec = ^rec_q[STAGES-1];

    function automatic logic fwd_hit(input rec_t r, input logic [REG_W-1:0] sel);
        return r.valid & r.wen & (r.wsel != '0) & (r.wsel == sel);
    endfunction

    assign advance  = bus.mem_req ? bus.dhit : bus.ihit;
    assign hz       = rec_q[1].valid & rec_q[1].load & (rec_q[1].wsel != '0) &
                      ((rec_q[1].wsel == bus.dec_rsel1) |
                       (bus.dec_uses_rt & (rec_q[1].wsel == bus.dec_rsel2)));
    assign shift_en = advance & ~halt_q;

    always_comb begin
        pc_en      = 1'b0;
        pipe_en    = '0;
        flush      = '0;
        stall_load = 1'b0;
        if (shift_en) begin
            if (bus.br_taken) begin
                pc_en    = 1'b1;
                pipe_en  = '1;
                flush[0] = 1'b1;
                flush[1] = 1'b1;
            end else if (hz) begin
                // IF/ID holds the dependent instruction; a bubble enters ID/EX.
                pipe_en    = '1;
                pipe_en[0] = 1'b0;
                flush[1]   = 1'b1;
                stall_load = 1'b1;
            end else if (bus.mem_req) begin
                pipe_en  = '1;
                flush[0] = 1'b1;
            end else begin
                pc_en   = 1'b1;
                pipe_en = '1;
            end
        end
    end

    always_comb begin
        rec_d  = rec_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        urt_d  = urt_q;
        halt_d = halt_q | (rec_q[2].valid & rec_q[2].halt);
        if (shift_en) begin
            for (int k = 2; k < STAGES; k++) rec_d[k] = rec_q[k-1];
            if (flush[1]) begin
                rec_d[1] = '0;
                rs1_d    = '0;
                rs2_d    = '0;
                urt_d    = 1'b0;
            end else begin
                rec_d[1].valid = 1'b1;
                rec_d[1].wen   = bus.dec_wen;
                rec_d[1].wsel  = bus.dec_wsel;
                rec_d[1].load  = bus.dec_load;
                rec_d[1].halt  = bus.dec_halt;
                rs1_d          = bus.dec_rsel1;
                rs2_d          = bus.dec_rsel2;
                urt_d          = bus.dec_uses_rt;
            end
        end
    end

    // Scan from the oldest stage toward stage 2 so the nearest producer wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = STAGES-1; k >= 2; k--) begin
            if (fwd_hit(rec_q[k], rs1_q))          fwd_a = FW'(k);
            if (urt_q && fwd_hit(rec_q[k], rs2_q)) fwd_b = FW'(k);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rec_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            urt_q  <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            rec_q  <= rec_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            urt_q  <= urt_d;
            halt_q <= halt_d;
        end
    end

    assign bus.pc_en      = pc_en;
    assign bus.pipe_en    = pipe_en;
    assign bus.flush      = flush;
    assign bus.fwd_a      = fwd_a;
    assign bus.fwd_b      = fwd_b;
    assign bus.halt       = halt_q;
    assign bus.stall_load = stall_load;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] cyc_q, cyc_d, stall_q, stall_d, flsh_q, flsh_d;

    always_comb begin
        cyc_d   = cyc_q;
        stall_d = stall_q;
        flsh_d  = flsh_q;
        if (!halt_q) begin
            cyc_d = cyc_q + 32'd1;
            if (!advance || hz)          stall_d = stall_q + 32'd1;
            if (advance && bus.br_taken) flsh_d  = flsh_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cyc_q   <= '0;
            stall_q <= '0;
            flsh_q  <= '0;
        end else begin
            cyc_q   <= cyc_d;
            stall_q <= stall_d;
            flsh_q  <= flsh_d;
        end
    end

    assign cyc_cnt   = cyc_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flsh_q;
`endif
endmodule
